// File: rtl/msrv32_dmem_responder.sv
// msrv32_dmem_responder: data-bus RAM slave with programmable wait states and a two-cycle error response.
// Optional MSRV32_DMEM_ALIGN_CHECK_EN turns writes with an irregular or misaligned byte mask into errors.
module msrv32_dmem_responder #(
  parameter int          DEPTH_WORDS = 1024,
  parameter logic [31:0] BASE_ADDR   = 32'h0001_0000,
  parameter int          WAIT_STATES = 1
) (
  input  logic        ms_riscv32_mp_clk_in,
  input  logic        ms_riscv32_mp_rst_in,
  input  logic [31:0] dmaddr_in,
  input  logic [31:0] dmdata_in,
  input  logic        dmwr_req_in,
  input  logic [3:0]  dmwr_mask_in,
  input  logic [1:0]  data_htrans_in,
  output logic [31:0] data_out,
  output logic        data_hready_out,
  output logic        hresp_out
);

  localparam int         AW        = $clog2(DEPTH_WORDS);
  localparam logic [3:0] WAIT_INIT = 4'(WAIT_STATES);

  typedef enum logic [1:0] {IDLE, BUSY, ERR1, ERR2} state_t;

  state_t        state_q, state_d;
  logic [3:0]    cnt_q, cnt_d;
  logic [AW-1:0] idx_q;
  logic          wr_q;
  logic [3:0]    mask_q;
  logic [31:0]   wdata_q;
  logic [31:0]   mem [DEPTH_WORDS];

  logic [31:0]   offset;
  logic          in_range;
  logic [AW-1:0] idx_in;
  logic          align_err;
  logic          req;
  logic          accept;
  logic          commit;
  logic          rd_load;
  logic [AW-1:0] rd_idx;
  logic [31:0]   rd_word;
  logic [1:0]    unused_bits;

  // BASE_ADDR is aligned to the RAM span, so range is just "no bits above the index are set".
  assign offset      = dmaddr_in - BASE_ADDR;
  assign in_range    = (offset[31:AW+2] == '0);
  assign idx_in      = offset[AW+1:2];
  assign unused_bits = offset[1:0];
  assign req         = (data_htrans_in == 2'b10);

`ifdef MSRV32_DMEM_ALIGN_CHECK_EN
  logic       mask_legal;
  logic [1:0] low_lane;

  always_comb begin
    mask_legal = 1'b0;
    low_lane   = 2'd0;
    case (dmwr_mask_in)
      4'b0001, 4'b0011, 4'b1111: begin mask_legal = 1'b1; low_lane = 2'd0; end
      4'b0010:                   begin mask_legal = 1'b1; low_lane = 2'd1; end
      4'b0100, 4'b1100:          begin mask_legal = 1'b1; low_lane = 2'd2; end
      4'b1000:                   begin mask_legal = 1'b1; low_lane = 2'd3; end
      default:                   ;
    endcase
  end

  assign align_err = dmwr_req_in && (!mask_legal || (low_lane != dmaddr_in[1:0]));
`else
  assign align_err = 1'b0;
`endif

  // NOTE: every signal gets a default before the case so no path leaves one unassigned (no latches).
  always_comb begin
    state_d         = state_q;
    cnt_d           = cnt_q;
    accept          = 1'b0;
    commit          = 1'b0;
    rd_load         = 1'b0;
    data_hready_out = 1'b1;
    hresp_out       = 1'b0;
    case (state_q)
      IDLE: accept = req;
      BUSY: begin
        if (cnt_q != 4'd0) begin
          data_hready_out = 1'b0;
          cnt_d           = cnt_q - 4'd1;
          rd_load         = (cnt_q == 4'd1) && !wr_q;
        end else begin
          commit  = wr_q;
          accept  = req;
          state_d = IDLE;
        end
      end
      ERR1: begin
        data_hready_out = 1'b0;
        hresp_out       = 1'b1;
        state_d         = ERR2;
      end
      ERR2: begin
        hresp_out = 1'b1;
        state_d   = IDLE;
      end
      default: state_d = IDLE;
    endcase

    if (accept) begin
      if (!in_range || align_err) begin
        state_d = ERR1;
        cnt_d   = 4'd0;
      end else begin
        state_d = BUSY;
        cnt_d   = WAIT_INIT;
        rd_load = (WAIT_INIT == 4'd0) && !dmwr_req_in;
      end
    end
  end

  // A zero-wait read loads on its accept edge, which may be the same edge a write to that word commits.
  always_comb begin
    rd_idx  = accept ? idx_in : idx_q;
    rd_word = mem[rd_idx];
    if (commit && (idx_q == rd_idx)) begin
      for (int b = 0; b < 4; b++) begin
        if (mask_q[b]) rd_word[8*b +: 8] = wdata_q[8*b +: 8];
      end
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge ms_riscv32_mp_clk_in) begin
    if (!ms_riscv32_mp_rst_in) begin
      state_q  <= IDLE;
      cnt_q    <= 4'd0;
      idx_q    <= '0;
      wr_q     <= 1'b0;
      mask_q   <= 4'd0;
      wdata_q  <= 32'd0;
      data_out <= 32'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      if (accept) begin
        idx_q   <= idx_in;
        wr_q    <= dmwr_req_in;
        mask_q  <= dmwr_mask_in;
        wdata_q <= dmdata_in;
      end
      if (rd_load) data_out <= rd_word;
    end
  end

  // NOTE: the RAM array has no reset so it maps onto memory macros; reset only blocks a pending commit.
  always_ff @(posedge ms_riscv32_mp_clk_in) begin
    if (ms_riscv32_mp_rst_in && commit) begin
      for (int b = 0; b < 4; b++) begin
        if (mask_q[b]) mem[idx_q][8*b +: 8] <= wdata_q[8*b +: 8];
      end
    end
  end

endmodule

// File: tb/tb_msrv32_dmem_responder.sv
// Bench for msrv32_dmem_responder: three instances (0, 1 and 3 wait states) checked every cycle
// against a transfer-level timeline model, plus literal expectations from the test plan.
module tb_msrv32_dmem_responder;

  localparam logic [31:0] BASE = 32'h0001_0000;
  localparam int          NI   = 3;
  localparam int          TL   = 1024;

`ifdef MSRV32_DMEM_ALIGN_CHECK_EN
  localparam logic [31:0] W5_EXP = 32'h0000_0000;
`else
  localparam logic [31:0] W5_EXP = 32'h0034_5600;
`endif

  logic        clk   = 1'b0;
  logic        rst_n = 1'b0;
  logic [31:0] addr   [NI];
  logic [31:0] wdata  [NI];
  logic        wr     [NI];
  logic [3:0]  mask   [NI];
  logic [1:0]  htrans [NI];
  logic [31:0] rdata  [NI];
  logic        hready [NI];
  logic        hresp  [NI];

  // Model: expected outputs per instance per cycle, plus RAM image and one uncommitted write.
  logic        t_hready [NI][TL];
  logic        t_hresp  [NI][TL];
  logic [31:0] t_data   [NI][TL];
  logic [31:0] mem      [NI][1024];
  bit          pend_v    [NI];
  int          pend_idx  [NI];
  logic [3:0]  pend_mask [NI];
  logic [31:0] pend_data [NI];

  int cyc      = 0;
  bit cmp_en   = 1'b0;
  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  msrv32_dmem_responder #(.DEPTH_WORDS(16), .BASE_ADDR(BASE), .WAIT_STATES(0)) u_k0 (
    .ms_riscv32_mp_clk_in(clk), .ms_riscv32_mp_rst_in(rst_n),
    .dmaddr_in(addr[0]), .dmdata_in(wdata[0]), .dmwr_req_in(wr[0]), .dmwr_mask_in(mask[0]),
    .data_htrans_in(htrans[0]), .data_out(rdata[0]), .data_hready_out(hready[0]), .hresp_out(hresp[0]));

  msrv32_dmem_responder u_k1 (
    .ms_riscv32_mp_clk_in(clk), .ms_riscv32_mp_rst_in(rst_n),
    .dmaddr_in(addr[1]), .dmdata_in(wdata[1]), .dmwr_req_in(wr[1]), .dmwr_mask_in(mask[1]),
    .data_htrans_in(htrans[1]), .data_out(rdata[1]), .data_hready_out(hready[1]), .hresp_out(hresp[1]));

  msrv32_dmem_responder #(.DEPTH_WORDS(16), .BASE_ADDR(BASE), .WAIT_STATES(3)) u_k3 (
    .ms_riscv32_mp_clk_in(clk), .ms_riscv32_mp_rst_in(rst_n),
    .dmaddr_in(addr[2]), .dmdata_in(wdata[2]), .dmwr_req_in(wr[2]), .dmwr_mask_in(mask[2]),
    .data_htrans_in(htrans[2]), .data_out(rdata[2]), .data_hready_out(hready[2]), .hresp_out(hresp[2]));

  function automatic int ws_of(input int i);
    return (i == 0) ? 0 : (i == 1) ? 1 : 3;
  endfunction

  function automatic int depth_of(input int i);
    return (i == 1) ? 1024 : 16;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Outputs depend only on registered state, so sampling on the falling edge is race-free.
  always @(negedge clk) begin
    if (cmp_en && cyc < TL) begin
      for (int i = 0; i < NI; i++) begin
        check($sformatf("inst%0d hready cyc%0d", i, cyc), 32'(hready[i]), 32'(t_hready[i][cyc]));
        check($sformatf("inst%0d hresp cyc%0d", i, cyc), 32'(hresp[i]), 32'(t_hresp[i][cyc]));
        check($sformatf("inst%0d data cyc%0d", i, cyc), rdata[i], t_data[i][cyc]);
      end
    end
  end

  function automatic void set_tl(input int i, input int c, input logic h, input logic r);
    if (c < TL) begin
      t_hready[i][c] = h;
      t_hresp[i][c]  = r;
    end
  endfunction

  function automatic void commit_pending(input int i);
    if (pend_v[i]) begin
      for (int b = 0; b < 4; b++)
        if (pend_mask[i][b]) mem[i][pend_idx[i]][8*b +: 8] = pend_data[i][8*b +: 8];
      pend_v[i] = 1'b0;
    end
  endfunction

  function automatic bit is_err(input int i, input logic [31:0] a, input logic w, input logic [3:0] m);
    logic [31:0] off;
    bit          e;
    off = a - BASE;
    e   = (off >= 32'(4 * depth_of(i)));
`ifdef MSRV32_DMEM_ALIGN_CHECK_EN
    if (w && !e) begin
      bit legal;
      int low;
      legal = (m inside {4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0011, 4'b1100, 4'b1111});
      low   = 0;
      for (int b = 3; b >= 0; b--) if (m[b]) low = b;
      if (!legal || low != int'(a[1:0])) e = 1'b1;
    end
`endif
    return e;
  endfunction

  task automatic drive(input int i, input logic [31:0] a, input logic w, input logic [3:0] m,
                       input logic [31:0] d, input logic [1:0] t);
    addr[i]   = a;
    wr[i]     = w;
    mask[i]   = m;
    wdata[i]  = d;
    htrans[i] = t;
  endtask

  task automatic wait_cycle(input int t);
    while (cyc < t) @(negedge clk);
  endtask

  // Issue one transfer on instance i; n is the accept edge. While the model says the slave
  // cannot take an address, a stray write to word 0 is presented and must be ignored.
  task automatic xfer(input int i, input logic [31:0] a, input logic w, input logic [3:0] m,
                      input logic [31:0] d, output int n);
    int k;
    int idx;
    while (!(t_hready[i][cyc] && !t_hresp[i][cyc])) begin
      drive(i, BASE, 1'b1, 4'hF, 32'hBAD0_BAD0, 2'b10);
      @(negedge clk);
    end
    drive(i, a, w, m, d, 2'b10);
    n = cyc + 1;
    k = ws_of(i);
    commit_pending(i);
    if (is_err(i, a, w, m)) begin
      set_tl(i, n, 1'b0, 1'b1);
      set_tl(i, n + 1, 1'b1, 1'b1);
    end else begin
      idx = int'((a - BASE) >> 2);
      for (int c = n; c < n + k; c++) set_tl(i, c, 1'b0, 1'b0);
      set_tl(i, n + k, 1'b1, 1'b0);
      if (w) begin
        pend_v[i]    = 1'b1;
        pend_idx[i]  = idx;
        pend_mask[i] = m;
        pend_data[i] = d;
      end else begin
        for (int c = n + k; c < TL; c++) t_data[i][c] = mem[i][idx];
      end
    end
    @(negedge clk);
    drive(i, 32'd0, 1'b0, 4'd0, 32'd0, 2'b00);
  endtask

  // Reset asserted now is sampled on the next edge; all instances return to idle and drop pending writes.
  task automatic do_reset(input int edges);
    rst_n = 1'b0;
    for (int i = 0; i < NI; i++) begin
      pend_v[i] = 1'b0;
      drive(i, 32'd0, 1'b0, 4'd0, 32'd0, 2'b00);
      for (int c = cyc + 1; c < TL; c++) begin
        t_hready[i][c] = 1'b1;
        t_hresp[i][c]  = 1'b0;
        t_data[i][c]   = 32'd0;
      end
    end
    repeat (edges) @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    cmp_en = 1'b1;
    do_reset(2);
    for (int i = 0; i < NI; i++) begin
      check($sformatf("reset hready inst%0d", i), 32'(hready[i]), 32'd1);
      check($sformatf("reset hresp inst%0d", i), 32'(hresp[i]), 32'd0);
      check($sformatf("reset data inst%0d", i), rdata[i], 32'd0);
    end

    // One wait state: write then read back, low address bits ignored.
    xfer(1, BASE, 1'b1, 4'hF, 32'h0123_4567, n);
    xfer(1, BASE + 32'd8, 1'b1, 4'hF, 32'hDEAD_BEEF, n);
    xfer(1, BASE + 32'd8, 1'b0, 4'h0, 32'd0, n);
    check("k1 read stall", 32'(hready[1]), 32'd0);
    wait_cycle(n + 1);
    check("k1 read hready", 32'(hready[1]), 32'd1);
    check("k1 read data", rdata[1], 32'hDEAD_BEEF);
    xfer(1, BASE + 32'd11, 1'b0, 4'h0, 32'd0, n);
    wait_cycle(n + 1);
    check("k1 unaligned read", rdata[1], 32'hDEAD_BEEF);

    // Range boundaries on the 1024-word instance.
    xfer(1, BASE + 32'd4092, 1'b1, 4'hF, 32'h0F0F_0F0F, n);
    xfer(1, BASE + 32'd4092, 0, 4'h0, 32'd0, n);
    wait_cycle(n + 1);
    check("k1 last word", rdata[1], 32'h0F0F_0F0F);
    xfer(1, BASE + 32'd4096, 1'b0, 4'h0, 32'd0, n);
    check("err1 hready", 32'(hready[1]), 32'd0);
    check("err1 hresp", 32'(hresp[1]), 32'd1);
    wait_cycle(n + 1);
    check("err2 hready", 32'(hready[1]), 32'd1);
    check("err2 hresp", 32'(hresp[1]), 32'd1);
    wait_cycle(n + 2);
    check("post-err hresp", 32'(hresp[1]), 32'd0);
    xfer(1, BASE - 32'd4, 1'b1, 4'hF, 32'h7777_7777, n);
    xfer(1, BASE, 1'b0, 4'h0, 32'd0, n);
    wait_cycle(n + 1);
    check("k1 word0 unchanged", rdata[1], 32'h0123_4567);

    // Zero wait states: back-to-back with write-to-read forwarding.
    xfer(0, BASE, 1'b1, 4'hF, 32'h5555_0000, n);
    xfer(0, BASE + 32'd12, 1'b1, 4'hF, 32'hAAAA_AAAA, n);
    xfer(0, BASE + 32'd12, 1'b1, 4'b0011, 32'h1122_3344, n);
    xfer(0, BASE + 32'd12, 1'b0, 4'h0, 32'd0, n);
    check("k0 forward data", rdata[0], 32'hAAAA_3344);
    check("k0 hready", 32'(hready[0]), 32'd1);
    xfer(0, BASE + 32'd64, 1'b0, 4'h0, 32'd0, n);
    xfer(0, BASE, 1'b0, 4'h0, 32'd0, n);
    check("k0 word0 unchanged", rdata[0], 32'h5555_0000);

    // Irregular masks: partial write at offset 1 and an empty mask.
    xfer(0, BASE + 32'd20, 1'b1, 4'hF, 32'h0000_0000, n);
    xfer(0, BASE + 32'd21, 1'b1, 4'b0110, 32'h1234_5678, n);
    xfer(0, BASE + 32'd20, 1'b1, 4'b0000, 32'hFFFF_FFFF, n);
    xfer(0, BASE + 32'd20, 1'b0, 4'h0, 32'd0, n);
    check("k0 mask0110 word", rdata[0], W5_EXP);

    // Three wait states, then reset in the middle of a write.
    xfer(2, BASE + 32'd8, 1'b1, 4'hF, 32'hCAFE_F00D, n);
    xfer(2, BASE + 32'd8, 1'b0, 4'h0, 32'd0, n);
    wait_cycle(n + 2);
    check("k3 stall", 32'(hready[2]), 32'd0);
    wait_cycle(n + 3);
    check("k3 read data", rdata[2], 32'hCAFE_F00D);
    xfer(2, BASE + 32'd8, 1'b1, 4'hF, 32'h0000_0000, n);
    do_reset(1);
    check("k3 reset hready", 32'(hready[2]), 32'd1);
    check("k3 reset data", rdata[2], 32'd0);
    xfer(2, BASE + 32'd8, 1'b0, 4'h0, 32'd0, n);
    wait_cycle(n + 3);
    check("k3 write discarded", rdata[2], 32'hCAFE_F00D);

    repeat (3) @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/msrv32_dmem_responder.md
# msrv32_dmem_responder

Data-memory slave for the msrv32 core's data bus: it is the responder end of the core's data-side transfer interface. It accepts single transfers from the core, carrying address, write request, byte mask and store data. It stalls the core with a programmable number of wait states, then returns full-word read data or commits masked writes into an internal word-addressed RAM. Out-of-range accesses get a two-cycle error response. It sits in the SoC/testbench next to the core top.

## Interface
Parameters
- DEPTH_WORDS, 1024: RAM size in 32-bit words; power of two, ≥ 4.
- BASE_ADDR, 32'h0001_0000: byte address of word 0; aligned to 4*DEPTH_WORDS.
- WAIT_STATES, 1: data-phase stall cycles, 0..15.

Ports
- ms_riscv32_mp_clk_in  in  1  clock; all state on rising edge.
- ms_riscv32_mp_rst_in  in  1  reset; synchronous, active-low.
- dmaddr_in  in  32  byte address, sampled in address phase.
- dmdata_in  in  32  store data, sampled with address.
- dmwr_req_in  in  1  1 = write, 0 = read.
- dmwr_mask_in  in  4  byte enables for writes; bit i = byte lane i.
- data_htrans_in  in  2  2'b10 = NONSEQ (valid transfer); any other value = idle.
- data_out  out  32  full-word read data.
- data_hready_out  out  1  1 = current data phase completes / slave can accept an address.
- hresp_out  out  1  1 = error response.

## Operation
- Control states: IDLE, BUSY, ERR1, ERR2. Reset → IDLE, data_hready_out=1, hresp_out=0, data_out=0, wait counter=0, address/control registers=0. RAM contents are not reset.
- Accept: transfer accepted on an edge where data_htrans_in==2'b10 and data_hready_out==1 in state IDLE or BUSY. Address, wr, mask and data are registered.
- Range check: word index = (dmaddr_in − BASE_ADDR)>>2. In range iff BASE_ADDR ≤ addr < BASE_ADDR+4*DEPTH_WORDS. addr[1:0] is ignored for range and indexing.
- Accepted and in range → BUSY, counter loaded with WAIT_STATES. Out of range → ERR1, no RAM access.
- BUSY, counter≠0: data_hready_out=0, counter decrements. Counter==0: data_hready_out=1 (final data-phase cycle).
- Final data-phase cycle:
  - Reads: data_out holds RAM[index] for that cycle.
  - Writes: lanes with mask=1 are written at the closing edge. data_out is unchanged.
  - A new transfer may be accepted on the same edge (pipelined). Otherwise → IDLE.
- ERR1: data_hready_out=0, hresp_out=1 → ERR2. ERR2: data_hready_out=1, hresp_out=1. Any transfer presented in ERR2 is ignored. → IDLE.
- Write→read forwarding: if a read of word W is accepted on the edge where a write to W commits, the read returns the post-write merged word.
- Read data register: loaded on the edge that enters the final data-phase cycle. When WAIT_STATES=0 this is the accept edge, with forwarding applied.

## Timing
- WAIT_STATES=k, in range: accept at edge N. data_hready_out is low for cycles N..N+k−1 and high in cycle N+k. Read data is valid in cycle N+k. The write commits at edge N+k+1.
- k=0: back-to-back transfers complete every cycle and data_hready_out stays 1.
- Error: accept at N; ERR1 cycle N (hready=0, hresp=1); ERR2 cycle N+1 (hready=1, hresp=1); IDLE from N+2.
- Reset asserted mid-transfer: the next edge returns to IDLE. A pending write is discarded. data_out is cleared.
- While data_hready_out=0, input changes are ignored.

## Configuration
- MSRV32_DMEM_ALIGN_CHECK_EN defined: an in-range write is treated as an error (ERR1/ERR2, no write) when either:
  - the mask is not one of 0001, 0010, 0100, 1000, 0011, 1100, 1111; or
  - the mask's lowest set lane ≠ addr[1:0].
  Reads are unaffected.
- Undefined: any mask is accepted and written as given. A mask of 0000 completes normally with no change.

## Test plan
- Reset with rst_in=0 for 2 edges → data_hready_out=1, hresp_out=0, data_out=0.
- WAIT_STATES=1: write 0xDEADBEEF, mask 1111, to BASE_ADDR+8, then read it → hready low 1 cycle per transfer; read returns 0xDEADBEEF.
- WAIT_STATES=0: back-to-back write 0x11223344 mask 0011 to word 3 (old 0xAAAAAAAA), then read word 3 → hready stays 1; read returns 0xAAAA3344 via forwarding.
- Read at BASE_ADDR+4*DEPTH_WORDS → ERR1 (hready=0, hresp=1), then ERR2 (hready=1, hresp=1), then IDLE. A later read of BASE_ADDR shows RAM unchanged.
- With MSRV32_DMEM_ALIGN_CHECK_EN: write mask 0110 at addr offset 1 → error response, word unchanged. Without the macro, bytes 1–2 are written.
- Reset during a WAIT_STATES=3 write → IDLE on the next edge; later read shows the original data.
